// File: rtl/gfx256_pixel_reader_if.sv
`default_nettype none
// ============================================================================
// gfx256_pixel_reader_if : request, memory-bus and pixel-stream signals
// Revision: 1.0
// ============================================================================
interface gfx256_pixel_reader_if #(
   parameter int CNT_W = 16
);
   logic             req_valid_i;
   logic             req_ready_o;
   logic [31:0]      req_addr_i;
   logic [CNT_W-1:0] req_cnt_i;
   logic [5:0]       cbpp_i;
   logic             inval_i;
   logic             m_cyc_o;
   logic             m_stb_o;
   logic [23:0]      m_lin_o;
   logic [31:0]      m_sel_o;
   logic [255:0]     m_dat_i;
   logic             m_ack_i;
   logic             m_err_i;
   logic             pix_valid_o;
   logic             pix_ready_i;
   logic [31:0]      pix_color_o;
   logic             pix_last_o;
   logic             busy_o;
   logic             err_o;

   modport slave (
      input  req_valid_i, req_addr_i, req_cnt_i, cbpp_i, inval_i,
      input  m_dat_i, m_ack_i, m_err_i, pix_ready_i,
      output req_ready_o, m_cyc_o, m_stb_o, m_lin_o, m_sel_o,
      output pix_valid_o, pix_color_o, pix_last_o, busy_o, err_o
   );

   modport master (
      output req_valid_i, req_addr_i, req_cnt_i, cbpp_i, inval_i,
      output m_dat_i, m_ack_i, m_err_i, pix_ready_i,
      input  req_ready_o, m_cyc_o, m_stb_o, m_lin_o, m_sel_o,
      input  pix_valid_o, pix_color_o, pix_last_o, busy_o, err_o
   );
endinterface
`default_nettype wire

// File: rtl/gfx256_pixel_reader.sv
`default_nettype none
// ============================================================================
// gfx256_pixel_reader : streams packed pixels out of a one-line 256-bit cache
// Revision: 1.0
// ============================================================================
module gfx256_pixel_reader #(
   parameter int CNT_W = 16
) (
   input  wire logic             clk_i,
   input  wire logic             rst_ni,
   gfx256_pixel_reader_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      STREAM = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [23:0]      r_line;
   logic [7:0]       r_mb;
   logic [CNT_W-1:0] r_cnt;
   logic [5:0]       r_cbpp;
   logic [255:0]     r_linebuf;
   logic [23:0]      r_tag;
   logic             r_tag_valid;
   logic             r_err;
   logic             r_inval_pend;

   logic             w_accept;
   logic             w_cbpp_ok;
   logic             w_hit;
   logic             w_next_hit;
   logic             w_pix_hs;
   logic [8:0]       w_mb_sum;
   logic [23:0]      w_next_line;
   logic [31:0]      w_mask;
   logic [287:0]     w_ext;

   always_comb begin
      w_cbpp_ok = 1'b0;
      case (bus.cbpp_i)
         6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32: w_cbpp_ok = 1'b1;
         default:                              w_cbpp_ok = 1'b0;
      endcase
   end

   // A same-cycle or pending invalidate must not let the accept see a stale hit.
   assign w_accept    = bus.req_valid_i & (r_state == IDLE);
   assign w_hit       = r_tag_valid & ~r_inval_pend & ~bus.inval_i
                        & (r_tag == bus.req_addr_i[31:8]);
   assign w_mb_sum    = {1'b0, r_mb} + {3'b000, r_cbpp};
   assign w_next_line = r_line + 24'd1;
   assign w_next_hit  = r_tag_valid & (r_tag == w_next_line);
   assign w_pix_hs    = (r_state == STREAM) & (r_cnt != '0) & bus.pix_ready_i;
   assign w_mask      = (r_cbpp == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << r_cbpp) - 32'd1);
   assign w_ext       = {32'd0, r_linebuf};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next          = r_state;
      bus.req_ready_o = 1'b0;
      bus.m_cyc_o     = 1'b0;
      bus.m_stb_o     = 1'b0;
      bus.m_lin_o     = 24'd0;
      bus.m_sel_o     = 32'd0;
      bus.pix_valid_o = 1'b0;
      bus.pix_color_o = 32'd0;
      bus.pix_last_o  = 1'b0;
      case (r_state)
         IDLE: begin
            bus.req_ready_o = 1'b1;
            if (w_accept && w_cbpp_ok) begin
               if (bus.req_cnt_i == '0 || w_hit) w_next = STREAM;
               else                              w_next = FETCH;
            end
         end
         FETCH: begin
            bus.m_cyc_o = 1'b1;
            bus.m_stb_o = 1'b1;
            bus.m_lin_o = r_line;
            bus.m_sel_o = 32'hFFFF_FFFF;
            if (bus.m_err_i)      w_next = IDLE;
            else if (bus.m_ack_i) w_next = STREAM;
         end
         STREAM: begin
            // A zero-count request spends exactly one cycle here with no pixel.
            if (r_cnt == '0) begin
               w_next = IDLE;
            end else begin
               bus.pix_valid_o = 1'b1;
               bus.pix_color_o = w_ext[{1'b0, r_mb} +: 32] & w_mask;
               bus.pix_last_o  = (r_cnt == CNT_W'(1));
               if (bus.pix_ready_i) begin
                  if (r_cnt == CNT_W'(1))           w_next = IDLE;
                  else if (w_mb_sum[8] && !w_next_hit) w_next = FETCH;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   assign bus.busy_o = (r_state != IDLE);
   assign bus.err_o  = r_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_line       <= 24'd0;
         r_mb         <= 8'd0;
         r_cnt        <= '0;
         r_cbpp       <= 6'd0;
         r_linebuf    <= 256'd0;
         r_tag        <= 24'd0;
         r_tag_valid  <= 1'b0;
         r_err        <= 1'b0;
         r_inval_pend <= 1'b0;
      end else begin
         if (r_state == IDLE && (bus.inval_i || r_inval_pend)) begin
            r_tag_valid  <= 1'b0;
            r_inval_pend <= 1'b0;
         end else if (r_state != IDLE && bus.inval_i) begin
            r_inval_pend <= 1'b1;
         end
         if (w_accept) begin
            r_err  <= ~w_cbpp_ok;
            r_line <= bus.req_addr_i[31:8];
            r_mb   <= bus.req_addr_i[7:0];
            r_cnt  <= bus.req_cnt_i;
            r_cbpp <= bus.cbpp_i;
         end
         if (r_state == FETCH) begin
            if (bus.m_err_i) begin
               r_err       <= 1'b1;
               r_tag_valid <= 1'b0;
            end else if (bus.m_ack_i) begin
               r_linebuf   <= bus.m_dat_i;
               r_tag       <= r_line;
               r_tag_valid <= 1'b1;
            end
         end
         if (w_pix_hs) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_mb  <= w_mb_sum[7:0];
            if (w_mb_sum[8]) r_line <= w_next_line;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_gfx256_pixel_reader.sv
`default_nettype none
// ============================================================================
// tb_gfx256_pixel_reader : randomized bench against a bit-address pixel model
// Revision: 1.0
// ============================================================================
module tb_gfx256_pixel_reader;
   localparam int CNT_W = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   gfx256_pixel_reader_if #(.CNT_W(CNT_W)) bus ();
   gfx256_pixel_reader #(.CNT_W(CNT_W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));

   int n_cmp  = 0;
   int n_fail = 0;

   logic [255:0] mem [int];
   int           ack_wait   = 0;
   int           ack_cnt    = 0;
   bit           err_inject = 0;
   int           stb_cycles = 0;
   logic [23:0]  fetch_q[$];

   bit           mc_valid = 0;
   logic [23:0]  mc_tag   = '0;
   bit           m_err    = 0;
   logic [31:0]  exp_pix[$];
   logic [23:0]  exp_fetch[$];

   logic [31:0]  got_pix[$];
   bit           got_last[$];
   int           first_valid_k, first_stb_k, busy_k, stall_k, unstable;

   function automatic logic [255:0] line_data(input logic [23:0] l);
      logic [255:0] d;
      if (mem.exists(int'(l))) return mem[int'(l)];
      for (int w = 0; w < 8; w++)
         d[w*32 +: 32] = ({8'h0, l} * 32'h9E37_79B1) ^ (32'h0101_0101 * (w + 1)) ^ 32'h5A5A_C3C3;
      return d;
   endfunction

   // Memory slave: acks (or errors) after ack_wait strobe cycles.
   always @(negedge clk) begin
      if (!rst_n) begin
         bus.m_ack_i = 1'b0;
         bus.m_err_i = 1'b0;
         ack_cnt     = 0;
      end else if (bus.m_ack_i || bus.m_err_i) begin
         bus.m_ack_i = 1'b0;
         bus.m_err_i = 1'b0;
      end else if (bus.m_cyc_o && bus.m_stb_o) begin
         stb_cycles++;
         if (ack_cnt < ack_wait) ack_cnt++;
         else begin
            ack_cnt = 0;
            if (err_inject) bus.m_err_i = 1'b1;
            else begin
               bus.m_ack_i = 1'b1;
               bus.m_dat_i = line_data(bus.m_lin_o);
               fetch_q.push_back(bus.m_lin_o);
            end
         end
      end
   end

   // Pixel i sits at bit address addr + i*cbpp; a fetch happens whenever the
   // line holding that address is not the single cached line.
   function automatic void model_req(input logic [31:0] addr, input int cnt, input logic [5:0] cbpp);
      logic [31:0] ba;
      logic [63:0] mask;
      logic [23:0] ln;
      exp_pix.delete();
      exp_fetch.delete();
      if (!(cbpp inside {6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32})) begin
         m_err = 1;
         return;
      end
      m_err = 0;
      mask  = (64'd1 << cbpp) - 64'd1;
      ba    = addr;
      for (int i = 0; i < cnt; i++) begin
         ln = ba[31:8];
         if (!(mc_valid && mc_tag == ln)) begin
            if (err_inject) begin
               m_err    = 1;
               mc_valid = 0;
               return;
            end
            exp_fetch.push_back(ln);
            mc_valid = 1;
            mc_tag   = ln;
         end
         exp_pix.push_back(32'(line_data(ln) >> ba[7:0]) & mask[31:0]);
         ba += 32'(cbpp);
      end
   endfunction

   task automatic do_inval();
      @(negedge clk);
      bus.inval_i = 1'b1;
      @(negedge clk);
      bus.inval_i = 1'b0;
      mc_valid = 0;
   endtask

   task automatic run_req(input logic [31:0] addr, input int cnt, input logic [5:0] cbpp,
                          input int ready_pct, input int hold_n);
      bit          prev_stall = 0;
      logic [31:0] prev_col   = '0;
      bit          prev_last  = 0;
      int          hold_left  = hold_n;
      bit          rdy;
      bit          done = 0;
      got_pix.delete();
      got_last.delete();
      fetch_q.delete();
      stb_cycles    = 0;
      first_valid_k = -1;
      first_stb_k   = -1;
      busy_k        = 0;
      stall_k       = 0;
      unstable      = 0;
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = addr;
      bus.req_cnt_i   = CNT_W'(cnt);
      bus.cbpp_i      = cbpp;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      for (int k = 1; k <= 3000; k++) begin
         if (!bus.busy_o) begin
            done = 1;
            break;
         end
         busy_k++;
         if (bus.m_stb_o && first_stb_k < 0) first_stb_k = k;
         if (bus.pix_valid_o) begin
            if (first_valid_k < 0) first_valid_k = k;
            if (prev_stall && (bus.pix_color_o !== prev_col || bus.pix_last_o !== prev_last)) unstable++;
            if (hold_left > 0) begin
               rdy = 0;
               hold_left--;
            end else rdy = ($urandom_range(99) < ready_pct);
            if (rdy) begin
               got_pix.push_back(bus.pix_color_o);
               got_last.push_back(bus.pix_last_o);
            end else stall_k++;
            prev_stall = !rdy;
            prev_col   = bus.pix_color_o;
            prev_last  = bus.pix_last_o;
         end else begin
            rdy = 0;
            if (prev_stall) unstable++;
            prev_stall = 0;
         end
         bus.pix_ready_i = rdy;
         @(negedge clk);
      end
      bus.pix_ready_i = 1'b0;
      n_cmp++;
      if (!done) begin
         n_fail++;
         $display("FAIL timeout: request addr=%h still busy, busy=%0d required=0", addr, bus.busy_o);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({bus.req_ready_o, bus.busy_o, bus.err_o} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_ctrl: ready/busy/err=%b required 100", {bus.req_ready_o, bus.busy_o, bus.err_o});
      end
      n_cmp++;
      if ({bus.m_cyc_o, bus.m_stb_o, bus.pix_valid_o, bus.pix_last_o} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_strobes: cyc/stb/valid/last=%b required 0000",
                  {bus.m_cyc_o, bus.m_stb_o, bus.pix_valid_o, bus.pix_last_o});
      end
      n_cmp++;
      if ({bus.m_lin_o, bus.m_sel_o, bus.pix_color_o} !== 88'd0) begin
         n_fail++;
         $display("FAIL reset_data: lin=%h sel=%h color=%h required 0", bus.m_lin_o, bus.m_sel_o, bus.pix_color_o);
      end
      rst_n = 1'b1;
      mc_valid = 0;
   endtask

   task automatic test_basic();
      logic [31:0] want[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      mem[1]          = 256'd0;
      mem[1][31:0]    = 32'h4433_2211;
      mem[1][255:240] = 16'hBEEF;
      ack_wait = 2;
      model_req(32'h100, 4, 6'd8);
      run_req(32'h100, 4, 6'd8, 100, 0);
      n_cmp++;
      if (fetch_q.size() != 1 || (fetch_q.size() == 1 && fetch_q[0] !== 24'd1)) begin
         n_fail++;
         $display("FAIL basic_fetch: fetches=%0d required 1 of line 1", fetch_q.size());
      end
      n_cmp++;
      if (first_stb_k != 1) begin
         n_fail++;
         $display("FAIL basic_stb_latency: first stb cycle=%0d required 1", first_stb_k);
      end
      n_cmp++;
      if (got_pix.size() != 4) begin
         n_fail++;
         $display("FAIL basic_count: got %0d pixels required 4", got_pix.size());
      end
      for (int i = 0; i < 4 && i < got_pix.size(); i++) begin
         n_cmp++;
         if (got_pix[i] !== want[i] || got_last[i] !== (i == 3)) begin
            n_fail++;
            $display("FAIL basic_pix%0d: got %h last=%0d required %h last=%0d", i, got_pix[i], got_last[i], want[i], i == 3);
         end
      end
   endtask

   task automatic test_hit_and_inval();
      model_req(32'h100, 4, 6'd8);
      run_req(32'h100, 4, 6'd8, 100, 0);
      n_cmp++;
      if (stb_cycles != 0 || first_valid_k != 1) begin
         n_fail++;
         $display("FAIL hit: stb cycles=%0d first valid=%0d required 0 and 1", stb_cycles, first_valid_k);
      end
      n_cmp++;
      if (got_pix.size() != 4 || (got_pix.size() == 4 && got_pix[3] !== 32'h44)) begin
         n_fail++;
         $display("FAIL hit_pixels: count=%0d required 4 ending 44", got_pix.size());
      end
      do_inval();
      model_req(32'h100, 4, 6'd8);
      run_req(32'h100, 4, 6'd8, 100, 0);
      n_cmp++;
      if (fetch_q.size() != 1) begin
         n_fail++;
         $display("FAIL inval_refetch: fetches=%0d required 1", fetch_q.size());
      end
   endtask

   task automatic test_cross();
      logic [255:0] l2 = line_data(24'd2);
      do_inval();
      ack_wait = 1;
      run_req(32'h1F0, 2, 6'd16, 100, 0);
      n_cmp++;
      if (fetch_q.size() != 2 || (fetch_q.size() == 2 && (fetch_q[0] !== 24'd1 || fetch_q[1] !== 24'd2))) begin
         n_fail++;
         $display("FAIL cross_fetch: fetches=%0d required lines 1 then 2", fetch_q.size());
      end
      n_cmp++;
      if (got_pix.size() != 2 || (got_pix.size() == 2 &&
          (got_pix[0] !== 32'h0000_BEEF || got_pix[1] !== {16'h0, l2[15:0]} || got_last[1] !== 1'b1))) begin
         n_fail++;
         $display("FAIL cross_pix: count=%0d required BEEF then %h", got_pix.size(), l2[15:0]);
      end
      mc_valid = 1;
      mc_tag   = 24'd2;
   endtask

   task automatic test_stall();
      model_req(32'h1000, 3, 6'd4);
      run_req(32'h1000, 3, 6'd4, 100, 5);
      n_cmp++;
      if (stall_k != 5 || unstable != 0) begin
         n_fail++;
         $display("FAIL stall_hold: stalled=%0d unstable=%0d required 5 and 0", stall_k, unstable);
      end
      n_cmp++;
      if (got_pix.size() != exp_pix.size()) begin
         n_fail++;
         $display("FAIL stall_count: got %0d required %0d", got_pix.size(), exp_pix.size());
      end
      foreach (got_pix[i]) if (i < exp_pix.size()) begin
         n_cmp++;
         if (got_pix[i] !== exp_pix[i] || got_last[i] !== (i == exp_pix.size() - 1)) begin
            n_fail++;
            $display("FAIL stall_pix%0d: got %h last=%0d required %h", i, got_pix[i], got_last[i], exp_pix[i]);
         end
      end
   endtask

   task automatic test_bus_err();
      err_inject = 1;
      model_req(32'h7700, 3, 6'd8);
      run_req(32'h7700, 3, 6'd8, 100, 0);
      n_cmp++;
      if (bus.err_o !== 1'b1 || got_pix.size() != 0 || first_valid_k != -1) begin
         n_fail++;
         $display("FAIL bus_err: err=%0d pixels=%0d required err=1 and no pixels", bus.err_o, got_pix.size());
      end
      err_inject = 0;
      model_req(32'h7700, 2, 6'd32);
      run_req(32'h7700, 2, 6'd32, 100, 0);
      n_cmp++;
      if (bus.err_o !== 1'b0 || fetch_q.size() != 1) begin
         n_fail++;
         $display("FAIL err_clear: err=%0d fetches=%0d required 0 and 1", bus.err_o, fetch_q.size());
      end
      n_cmp++;
      if (got_pix.size() != 2 || (got_pix.size() == 2 && got_pix[1] !== exp_pix[1])) begin
         n_fail++;
         $display("FAIL err_recover_pix: count=%0d required 2", got_pix.size());
      end
   endtask

   task automatic test_illegal_and_zero();
      model_req(32'h5000, 4, 6'd24);
      run_req(32'h5000, 4, 6'd24, 100, 0);
      n_cmp++;
      if (bus.err_o !== 1'b1 || busy_k != 0 || stb_cycles != 0) begin
         n_fail++;
         $display("FAIL illegal_cbpp: err=%0d busy=%0d stb=%0d required 1,0,0", bus.err_o, busy_k, stb_cycles);
      end
      model_req(32'h5000, 0, 6'd8);
      run_req(32'h5000, 0, 6'd8, 100, 0);
      n_cmp++;
      if (busy_k != 1 || stb_cycles != 0 || first_valid_k != -1 || bus.err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_cnt: busy=%0d stb=%0d valid@%0d err=%0d required 1,0,-1,0",
                  busy_k, stb_cycles, first_valid_k, bus.err_o);
      end
   endtask

   task automatic test_random();
      logic [5:0]  cb_tab[8] = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd24, 6'd3};
      logic [23:0] ln_tab[6] = '{24'd0, 24'd1, 24'd2, 24'd3, 24'd9, 24'hFF_FFFF};
      logic [5:0]  cb;
      logic [7:0]  mb;
      logic [31:0] addr;
      int          cnt;
      for (int it = 0; it < 30; it++) begin
         cb = cb_tab[$urandom_range(7)];
         if (cb inside {6'd24, 6'd3}) mb = 8'($urandom_range(255));
         else mb = 8'(int'(cb) * $urandom_range(256 / int'(cb) - 1));
         addr     = {ln_tab[$urandom_range(5)], mb};
         cnt      = $urandom_range(30);
         ack_wait = $urandom_range(3);
         if ($urandom_range(4) == 0) do_inval();
         model_req(addr, cnt, cb);
         run_req(addr, cnt, cb, $urandom_range(50, 100), 0);
         n_cmp++;
         if (bus.err_o !== m_err || got_pix.size() != exp_pix.size() || fetch_q.size() != exp_fetch.size()) begin
            n_fail++;
            $display("FAIL rand%0d_shape: err=%0d pix=%0d fetch=%0d required %0d %0d %0d", it,
                     bus.err_o, got_pix.size(), fetch_q.size(), m_err, exp_pix.size(), exp_fetch.size());
         end
         foreach (fetch_q[i]) if (i < exp_fetch.size()) begin
            n_cmp++;
            if (fetch_q[i] !== exp_fetch[i]) begin
               n_fail++;
               $display("FAIL rand%0d_fetch%0d: line %h required %h", it, i, fetch_q[i], exp_fetch[i]);
            end
         end
         foreach (got_pix[i]) if (i < exp_pix.size()) begin
            n_cmp++;
            if (got_pix[i] !== exp_pix[i] || got_last[i] !== (i == exp_pix.size() - 1)) begin
               n_fail++;
               $display("FAIL rand%0d_pix%0d: got %h last=%0d required %h", it, i, got_pix[i], got_last[i], exp_pix[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      int k = 0;
      @(negedge clk);
      bus.req_valid_i = 1'b1;
      bus.req_addr_i  = 32'h300;
      bus.req_cnt_i   = CNT_W'(8);
      bus.cbpp_i      = 6'd8;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      while (!bus.pix_valid_o && k < 50) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (bus.pix_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_reach: valid=%0d required 1", bus.pix_valid_o);
      end
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.req_ready_o, bus.busy_o, bus.err_o, bus.pix_valid_o, bus.pix_last_o, bus.m_cyc_o, bus.m_stb_o} !== 7'b1000000) begin
         n_fail++;
         $display("FAIL midrst_ctrl: %b required 1000000", {bus.req_ready_o, bus.busy_o, bus.err_o,
                  bus.pix_valid_o, bus.pix_last_o, bus.m_cyc_o, bus.m_stb_o});
      end
      n_cmp++;
      if ({bus.m_lin_o, bus.m_sel_o, bus.pix_color_o} !== 88'd0) begin
         n_fail++;
         $display("FAIL midrst_data: lin=%h sel=%h color=%h required 0", bus.m_lin_o, bus.m_sel_o, bus.pix_color_o);
      end
      @(negedge clk);
      rst_n    = 1'b1;
      mc_valid = 0;
      model_req(32'h300, 1, 6'd8);
      run_req(32'h300, 1, 6'd8, 100, 0);
      n_cmp++;
      if (fetch_q.size() != 1 || got_pix.size() != 1 || (got_pix.size() == 1 && got_pix[0] !== exp_pix[0])) begin
         n_fail++;
         $display("FAIL midrst_refetch: fetches=%0d pixels=%0d required 1 and 1", fetch_q.size(), got_pix.size());
      end
   endtask

   initial begin
      bus.req_valid_i = 1'b0;
      bus.req_addr_i  = '0;
      bus.req_cnt_i   = '0;
      bus.cbpp_i      = '0;
      bus.inval_i     = 1'b0;
      bus.pix_ready_i = 1'b0;
      bus.m_dat_i     = '0;
      bus.m_ack_i     = 1'b0;
      bus.m_err_i     = 1'b0;
      test_reset();
      test_basic();
      test_hit_and_inval();
      test_cross();
      test_stall();
      test_bus_err();
      test_illegal_and_zero();
      test_random();
      test_reset_mid_stream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/gfx256_pixel_reader.md
GFX256_PIXEL_READER -- requirements
Module: gfx256_pixel_reader

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the pixel-count field.
REQ-002 SHALL have exactly one clock and an asynchronous, active-low reset: clk_i  in  1  rising-edge clock.
REQ-003 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-004 SHALL have port req_valid_i  in  1  request strobe.
REQ-005 SHALL have port req_ready_o  out  1  high only in IDLE.
REQ-006 SHALL have port req_addr_i  in  32  bit address of first pixel (line = [31:8], bit offset mb = [7:0]).
REQ-007 SHALL have port req_cnt_i  in  CNT_W  number of pixels to read.
REQ-008 SHALL have port cbpp_i  in  6  bits per pixel, sampled at request accept.
REQ-009 SHALL have port inval_i  in  1  invalidate cached line.
REQ-010 SHALL have ports m_cyc_o, m_stb_o  out  1  memory bus cycle/strobe; m_lin_o  out  24  line index; m_sel_o  out  32  byte selects; m_dat_i  in  256  read data; m_ack_i, m_err_i  in  1  completion/error.
REQ-011 SHALL have ports pix_valid_o  out  1; pix_ready_i  in  1; pix_color_o  out  32  pixel, zero-extended; pix_last_o  out  1  final pixel of request.
REQ-012 SHALL have ports busy_o  out  1  state != IDLE; err_o  out  1  sticky error flag.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, STREAM; IDLE -> FETCH on accept with cache miss; IDLE -> STREAM on accept with cache hit; FETCH -> STREAM on m_ack_i; STREAM -> FETCH on line crossing; STREAM -> IDLE after last pixel handshake.
REQ-014 SHALL accept a request when req_valid_i & req_ready_o, latching addr, cnt, cbpp, and clearing err_o.
REQ-015 SHALL treat cbpp values other than 1,2,4,8,16,32 as illegal: set err_o, stay IDLE, emit nothing.
REQ-016 SHALL treat req_cnt_i = 0 as legal: return to IDLE the cycle after accept, no memory access, no pixel output.
REQ-017 SHALL hold a 256-bit line buffer plus line tag and tag-valid bit; a hit is tag-valid & tag == addr[31:8].
REQ-018 SHALL, in FETCH, assert m_cyc_o and m_stb_o with m_lin_o = current line and m_sel_o = all ones until m_ack_i or m_err_i; at ack, capture m_dat_i, set tag and tag-valid.
REQ-019 SHALL, in STREAM, drive pix_valid_o = 1 and pix_color_o = (linebuf >> mb) masked to cbpp low bits, with upper bits zero.
REQ-020 SHALL hold pix_color_o and pix_last_o stable while pix_valid_o & !pix_ready_i.
REQ-021 SHALL, on each pixel handshake, decrement the count and advance the bit address by cbpp; when mb + cbpp reaches 256, increment the line and go to FETCH (or stay in STREAM if the new line hits).
REQ-022 SHALL assert pix_last_o with the pixel for which the remaining count = 1.
REQ-023 SHALL, on m_err_i in FETCH, deassert cyc/stb next cycle, set err_o, clear tag-valid, and go to IDLE without emitting further pixels.
REQ-024 SHALL clear tag-valid when inval_i is high in IDLE; inval_i outside IDLE SHALL take effect on return to IDLE.
REQ-025 SHALL have latency, for a miss, of: accept at cycle 0; stb at cycle 1; ack at cycle N; first pix_valid_o at N+1. For a hit: first pix_valid_o at cycle 1.
REQ-026 SHALL wrap the line index mod 2^24 when the line is incremented.

Reset
REQ-027 SHALL, while rst_ni = 0, immediately force state IDLE, req_ready_o = 1, m_cyc_o = m_stb_o = 0, m_lin_o = 0, m_sel_o = 0, pix_valid_o = pix_last_o = 0, pix_color_o = 0, busy_o = 0, err_o = 0, tag-valid = 0.
REQ-028 SHALL, when reset is asserted mid-FETCH or mid-STREAM, abandon the operation; a late m_ack_i after reset SHALL be ignored.

Verification
REQ-029 SHALL be tested with: addr = 0x100, cnt = 4, cbpp = 8, line 1 = bytes 0x11,0x22,0x33,0x44 -> one fetch of line 1; pixels 0x11, 0x22, 0x33, 0x44; pix_last_o on 0x44.
REQ-030 SHALL be tested with: a repeat of the same request with no inval_i -> no m_stb_o; first pixel at cycle 1; then inval_i followed by the repeat -> a refetch occurs.
REQ-031 SHALL be tested with: addr = 0x1F0, cnt = 2, cbpp = 16 -> fetch of line 1, pixel from bits 255:240, fetch of line 2, pixel from bits 15:0.
REQ-032 SHALL be tested with: pix_ready_i held low for 5 cycles -> pixel value and pix_last_o stable throughout; no pixel lost or duplicated.
REQ-033 SHALL be tested with: m_err_i on the fetch -> err_o = 1, state IDLE, no pix_valid_o; the next accepted request clears err_o.
REQ-034 SHALL be tested with: cbpp = 24 -> err_o = 1, no bus cycle; cnt = 0 -> busy_o for 1 cycle, no output; rst_ni pulsed low mid-STREAM -> all outputs at reset values in the same cycle.
